// File: rtl/fa_result_checker.sv
// fa_result_checker: receive-side self-checker for a 1-bit full adder.
// Accepts {a,b,cin} together with the adder response {s,c_out} over a
// vld/rdy handshake. It recomputes the golden sum and carry, keeps
// pass/fail tallies and captures the first mismatching vector. It raises
// done after NUM_VEC accepted vectors.
//
// Handshake: a vector is accepted on a rising clk edge where vld and rdy
// are both high. rdy is a registered decode of the RUN state. A vld
// while rdy is low is ignored, and nothing is buffered.
//
// Optional feature: define FA_COVERAGE_EN to record which {a,b,cin}
// combinations were seen in the current run (cov_hit). Without it,
// cov_hit is tied to zero.
module fa_result_checker #(
    parameter int CNT_W   = 16,
    parameter int NUM_VEC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vld,
    output logic             rdy,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    input  logic             s,
    input  logic             c_out,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_flag,
    output logic [4:0]       first_fail,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic             done,
    output logic [7:0]       cov_hit
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last_accept;
    logic             exp_s;
    logic             exp_c;
    logic             is_match;
    logic [CNT_W-1:0] vec_idx;

    // Counters stop at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign accept      = vld & rdy;
    // vec_idx counts the vectors accepted before this one. The vector that
    // brings the count up to NUM_VEC therefore arrives while vec_idx == NUM_VEC-1.
    assign last_accept = accept && (vec_idx == LAST_IDX);

    assign exp_s = a ^ b ^ cin;
    assign exp_c = (a & b) | (a & cin) | (b & cin);
    // An X or Z on s/c_out makes this condition unknown. The if/else below
    // then takes the mismatch branch, so unknown responses count as failures.
    assign is_match = (s == exp_s) && (c_out == exp_c);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode. start wins from every state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (start) state_nxt = RUN;
                     else if (last_accept) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // rdy and done are registered state decodes. They track state exactly,
    // so the final accept lowers rdy and raises done on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy  <= 1'b0;
            done <= 1'b0;
        end else begin
            rdy  <= (state_nxt == RUN);
            done <= (state_nxt == DONE);
        end
    end

    // Run statistics. start clears everything and drops any same-cycle vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            err_flag       <= 1'b0;
            first_fail     <= '0;
            first_fail_idx <= '0;
            vec_idx        <= '0;
        end else if (start) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            err_flag       <= 1'b0;
            first_fail     <= '0;
            first_fail_idx <= '0;
            vec_idx        <= '0;
        end else if (accept) begin
            vec_idx <= sat_inc(vec_idx);
            if (is_match) begin
                pass_cnt <= sat_inc(pass_cnt);
            end else begin
                fail_cnt <= sat_inc(fail_cnt);
                err_flag <= 1'b1;
                if (!err_flag) begin
                    first_fail     <= {a, b, cin, s, c_out};
                    first_fail_idx <= vec_idx;
                end
            end
        end
    end

`ifdef FA_COVERAGE_EN
    logic [7:0] cov_q;

    // Sticky per-run record of the {a,b,cin} combinations accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         cov_q <= 8'h00;
        else if (start)  cov_q <= 8'h00;
        else if (accept) cov_q[{a, b, cin}] <= 1'b1;
    end

    assign cov_hit = cov_q;
`else
    assign cov_hit = 8'h00;
`endif

endmodule

// File: tb/tb_fa_result_checker.sv
// tb_fa_result_checker: directed and randomized bench for fa_result_checker.
// A reference model tracks the run at the transaction level: whether a run
// is in progress, how many vectors were accepted, and the tallies computed
// from the arithmetic sum a+b+cin. Outputs are compared every cycle on the
// falling edge.
module tb_fa_result_checker;

    localparam int CNT_W   = 16;
    localparam int NUM_VEC = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             vld;
    logic             rdy;
    logic             a;
    logic             b;
    logic             cin;
    logic             s;
    logic             c_out;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             err_flag;
    logic [4:0]       first_fail;
    logic [CNT_W-1:0] first_fail_idx;
    logic             done;
    logic [7:0]       cov_hit;

    fa_result_checker #(.CNT_W(CNT_W), .NUM_VEC(NUM_VEC)) dut (
        .clk(clk), .rst(rst), .start(start), .vld(vld), .rdy(rdy),
        .a(a), .b(b), .cin(cin), .s(s), .c_out(c_out),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_flag(err_flag),
        .first_fail(first_fail), .first_fail_idx(first_fail_idx),
        .done(done), .cov_hit(cov_hit)
    );

    // Clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state.
    bit          m_run;
    bit          m_done;
    bit          m_err;
    int unsigned m_pass;
    int unsigned m_fail;
    int unsigned m_acc;
    int unsigned m_ffidx;
    logic [4:0]  m_ff;
    logic [7:0]  m_cov;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Correct {s,c_out} for a vector, taken from the arithmetic sum of the three bits.
    function automatic logic [1:0] good_sc(input logic [2:0] abc);
        logic [1:0] t;
        t = 2'(abc[2]) + 2'(abc[1]) + 2'(abc[0]);
        return {t[0], t[1]};
    endfunction

    task automatic model_clear();
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_pass  = 0;
        m_fail  = 0;
        m_acc   = 0;
        m_ffidx = 0;
        m_ff    = '0;
        m_cov   = '0;
    endtask

    // Model effect of one rising edge with the given inputs.
    task automatic model_edge(input logic st, input logic v, input logic [2:0] abc, input logic [1:0] sc);
        if (st) begin
            model_clear();
            m_run = 1'b1;
        end else if (m_run && v) begin
            if (sc == good_sc(abc)) begin
                m_pass++;
            end else begin
                m_fail++;
                if (!m_err) begin
                    m_ff    = {abc, sc};
                    m_ffidx = m_acc;
                end
                m_err = 1'b1;
            end
            m_cov[abc] = 1'b1;
            m_acc++;
            if (m_acc == NUM_VEC) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [7:0] exp_cov;
`ifdef FA_COVERAGE_EN
        exp_cov = m_cov;
`else
        exp_cov = 8'h00;
`endif
        check_val("rdy",            32'(rdy),            32'(m_run));
        check_val("done",           32'(done),           32'(m_done));
        check_val("pass_cnt",       32'(pass_cnt),       m_pass);
        check_val("fail_cnt",       32'(fail_cnt),       m_fail);
        check_val("err_flag",       32'(err_flag),       32'(m_err));
        check_val("first_fail",     32'(first_fail),     32'(m_ff));
        check_val("first_fail_idx", 32'(first_fail_idx), m_ffidx);
        check_val("cov_hit",        32'(cov_hit),        32'(exp_cov));
    endtask

    // Driver: apply one cycle of inputs from a falling edge, then check on the next falling edge.
    task automatic step(input logic st, input logic v, input logic [2:0] abc, input logic [1:0] sc);
        start = st;
        vld   = v;
        {a, b, cin} = abc;
        {s, c_out}  = sc;
        @(posedge clk);
        model_edge(st, v, abc, sc);
        @(negedge clk);
        start = 1'b0;
        vld   = 1'b0;
        check_outputs();
    endtask

    // Start a run and feed vectors 0..7 in order. Marked indices return a flipped sum bit.
    task automatic run_ordered(input logic [7:0] fault_mask);
        logic [2:0] abc;
        step(1'b1, 1'b0, 3'd0, 2'd0);
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            step(1'b0, 1'b1, abc, good_sc(abc) ^ (fault_mask[i] ? 2'b10 : 2'b00));
        end
    endtask

    task automatic run_random();
        logic [2:0] abc;
        logic [1:0] sc;
        logic       v;
        logic       st;
        step(1'b1, 1'b0, 3'd0, 2'd0);
        for (int i = 0; i < 200 && !m_done; i++) begin
            abc = 3'($urandom_range(0, 7));
            sc  = good_sc(abc);
            if ($urandom_range(0, 4) == 0) sc = sc ^ 2'($urandom_range(1, 3));
            v   = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 39) == 0);
            step(st, v, abc, sc);
        end
        check_val("rand_done", 32'(m_done), 32'd1);
        check_val("rand_total", 32'(pass_cnt) + 32'(fail_cnt), NUM_VEC);
    endtask

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    // Main sequence.
    initial begin
        rst = 1'b1; start = 1'b0; vld = 1'b0;
        a = 1'b0; b = 1'b0; cin = 1'b0; s = 1'b0; c_out = 1'b0;
        m_run = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // vld in IDLE is ignored.
        step(1'b0, 1'b1, 3'd3, good_sc(3'd3));
        step(1'b0, 1'b1, 3'd5, 2'b11);

        // Three accepts, then an asynchronous reset between clock edges.
        step(1'b1, 1'b0, 3'd0, 2'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'(i), good_sc(3'(i)));
        #2 rst = 1'b1;
        m_run = 1'b0;
        model_clear();
        #1 check_outputs();
        @(negedge clk);
        rst = 1'b0;
        check_val("t1_pass_cnt", 32'(pass_cnt), 32'd0);

        // Exhaustive clean run.
        run_ordered(8'h00);
        check_val("t2_pass_cnt", 32'(pass_cnt), 32'd8);
        check_val("t2_done",     32'(done),     32'd1);
        check_val("t2_rdy",      32'(rdy),      32'd0);

        // vld in DONE is ignored.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd6, 2'b00);

        // Single fault at vector 5.
        run_ordered(8'h20);
        check_val("t3_pass_cnt",   32'(pass_cnt),       32'd7);
        check_val("t3_first_fail", 32'(first_fail),     32'h17);
        check_val("t3_ff_idx",     32'(first_fail_idx), 32'd5);

        // Restart with a same-cycle vld: the vector is dropped and stats clear.
        step(1'b1, 1'b1, 3'd7, 2'b00);
        check_val("t6_clear_pass", 32'(pass_cnt), 32'd0);
        check_val("t6_clear_fail", 32'(fail_cnt), 32'd0);
        run_ordered(8'h00);
        check_val("t6_pass_cnt", 32'(pass_cnt), 32'd8);
        check_val("t6_err_flag", 32'(err_flag), 32'd0);

        // Two faults at vectors 2 and 6.
        run_ordered(8'h44);
        check_val("t4_fail_cnt", 32'(fail_cnt),       32'd2);
        check_val("t4_ff_idx",   32'(first_fail_idx), 32'd2);
        check_val("t4_err_flag", 32'(err_flag),       32'd1);

        // Randomized runs with gaps, faults and occasional restarts.
        for (int r = 0; r < 8; r++) run_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
